bus_if_gen2: RTL and testbench

- Parametrised second-generation CPU memory-stage bus interface.
- Routes each CPU access either to the local scratch-pad memory (SPM) in zero wait states, or to the shared bus through a request/grant/access handshake. The shared-bus access is a registered state machine.
- New over the previous generation: configurable widths and SPM slave index, a bus-access timeout with error reporting, and flush-abort of pending bus requests.
- Sits between the pipeline memory stage and both the SPM and the bus arbiter/slaves.

---
 rtl/bus_if_gen2_pkg.sv | 26 ++
 rtl/bus_if_gen2_timer.sv | 49 ++++
 rtl/bus_if_gen2.sv | 211 +++++++++++++++++++++
 tb/tb_bus_if_gen2.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_if_gen2_pkg.sv
// rtl/bus_if_gen2_pkg.sv - shared encodings and helpers for the gen2 memory-stage bus interface
package bus_if_gen2_pkg;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } bus_if_state_e;

    // CPU / bus direction encoding
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low strobe levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int unsigned SPM_INDEX_DEFAULT = 1;

    // Counter width able to hold 0..timeout; a disabled timeout still needs one bit
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_if_gen2_timer.sv
// rtl/bus_if_gen2_timer.sv - loadable/clearable up-counter with terminal-count flag
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr         force the count to zero (highest priority)
//   load        load load_val
//   load_val    value loaded when load is set
//   en          increment by one
//   tc          count equals TC_VAL
module bus_if_timer
    import bus_if_gen2_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned TC_VAL = 254
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == WIDTH'(TC_VAL));

endmodule

// File: rtl/bus_if_gen2.sv
// rtl/bus_if_gen2.sv - memory-stage bus interface routing CPU accesses to SPM or the shared bus
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall, flush          pipeline control from the CPU
//   addr, as_, rw,        CPU access (as_ active-low)
//   wr_data, rd_data
//   busy                  stall request back to the pipeline
//   bus_err               one-cycle pulse when a bus access times out
//   spm_*                 scratch-pad memory port (combinational pass-through)
//   bus_req_/bus_grnt_    arbiter handshake (active-low)
//   bus_addr/as_/rw/      registered shared-bus access, bus_rdy_ active-low
//   wr_data, bus_rd_data
module bus_if_gen2
    import bus_if_gen2_pkg::*;
#(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned SPM_INDEX = SPM_INDEX_DEFAULT,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              bus_err,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    input  logic              bus_grnt_,
    output logic              bus_req_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data
);

    localparam int unsigned TMR_W  = timer_width(TIMEOUT);
    localparam int unsigned TC_VAL = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    bus_if_state_e     state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_rw_q, bus_rw_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_tc;

    logic [IDX_W-1:0]  slave_idx;
    logic              req_valid;
    logic              is_spm;
    logic              timed_out;
    logic              next_is_stall;

    assign slave_idx = addr[ADDR_W-1 -: IDX_W];
    assign req_valid = (as_ == ENABLE_) && !flush;
    assign is_spm    = (slave_idx == IDX_W'(SPM_INDEX));

    // The timer holds the number of ACCESS cycles already elapsed, so the
    // terminal count marks the TIMEOUT-th cycle; a ready in that cycle wins.
    assign timed_out = (TIMEOUT != 0) && tmr_tc && (bus_rdy_ == DISABLE_);

    assign next_is_stall = stall;

    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_addr    = bus_addr_q;
    assign bus_rw      = bus_rw_q;
    assign bus_wr_data = bus_wr_data_q;

    bus_if_timer #(
        .WIDTH  (TMR_W),
        .TC_VAL (TC_VAL)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (tmr_clr),
        .load     (1'b0),
        .load_val ({TMR_W{1'b0}}),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_addr_d    = bus_addr_q;
        bus_rw_d      = bus_rw_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_buf_d      = rd_buf_q;
        rd_data       = '0;
        spm_as_       = DISABLE_;
        busy          = 1'b0;
        bus_err       = 1'b0;
        tmr_clr       = 1'b1;
        tmr_en        = 1'b0;

        case (state_q)
            BUS_IF_STATE_IDLE: begin
                if (req_valid) begin
                    if (is_spm) begin
                        // SPM is zero-wait; a stalled pipeline must not repeat the access
                        if (!stall) begin
                            spm_as_ = ENABLE_;
                            if (rw == READ) begin
                                rd_data = spm_rd_data;
                            end
                        end
                    end else begin
                        // Bus accesses start even under stall: the pipeline is held by busy
                        busy          = 1'b1;
                        state_d       = BUS_IF_STATE_REQ;
                        bus_req_d     = ENABLE_;
                        bus_addr_d    = addr;
                        bus_rw_d      = rw;
                        bus_wr_data_d = wr_data;
                    end
                end
            end

            BUS_IF_STATE_REQ: begin
                busy = 1'b1;
                if (flush) begin
                    state_d   = BUS_IF_STATE_IDLE;
                    bus_req_d = DISABLE_;
                end else if (bus_grnt_ == ENABLE_) begin
                    state_d  = BUS_IF_STATE_ACCESS;
                    bus_as_d = ENABLE_;
                end
            end

            BUS_IF_STATE_ACCESS: begin
                bus_as_d = DISABLE_;
                tmr_clr  = 1'b0;
                if (bus_rdy_ == ENABLE_) begin
                    if (bus_rw_q == READ) begin
                        rd_data  = bus_rd_data;
                        rd_buf_d = bus_rd_data;
                    end
                    bus_req_d = DISABLE_;
                    tmr_clr   = 1'b1;
                    state_d   = next_is_stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                end else if (timed_out) begin
                    bus_err   = 1'b1;
                    rd_buf_d  = '0;
                    bus_req_d = DISABLE_;
                    tmr_clr   = 1'b1;
                    state_d   = next_is_stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                end else begin
                    busy   = 1'b1;
                    tmr_en = 1'b1;
                end
            end

            BUS_IF_STATE_STALL: begin
                // Replay the completed read while the pipeline is frozen
                if (bus_rw_q == READ) begin
                    rd_data = rd_buf_q;
                end
                if (!stall) begin
                    state_d = BUS_IF_STATE_IDLE;
                end
            end

            default: begin
                state_d = BUS_IF_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BUS_IF_STATE_IDLE;
            bus_req_q     <= DISABLE_;
            bus_as_q      <= DISABLE_;
            bus_addr_q    <= '0;
            bus_rw_q      <= READ;
            bus_wr_data_q <= '0;
            rd_buf_q      <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_addr_q    <= bus_addr_d;
            bus_rw_q      <= bus_rw_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_buf_q      <= rd_buf_d;
        end
    end

endmodule

// File: tb/tb_bus_if_gen2.sv
// tb/tb_bus_if_gen2.sv - self-checking bench for bus_if_gen2 with a transaction-level model
module tb_bus_if_gen2;
    import bus_if_gen2_pkg::*;

    localparam int TO_CYC = 4;
    localparam int SPM_I  = 1;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [29:0] addr;
    logic        cpu_as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        busy;
    logic        bus_err;
    logic [31:0] spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        bus_grnt_;
    logic        bus_req_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;

    int checks;
    int failures;

    bus_if_gen2 #(
        .ADDR_W    (30),
        .DATA_W    (32),
        .IDX_W     (3),
        .SPM_INDEX (SPM_I),
        .TIMEOUT   (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .addr        (addr),
        .as_         (cpu_as_),
        .rw          (rw),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .bus_err     (bus_err),
        .spm_rd_data (spm_rd_data),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .bus_grnt_   (bus_grnt_),
        .bus_req_    (bus_req_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: where the current transaction is, plus what the bus side last latched.
    // phase: 0 no bus transaction, 1 waiting for grant, 2 bus cycle running, 3 result held
    int          m_phase;
    int          m_waited;      // bus-cycle clocks already spent without ready
    logic        m_req_low;
    logic        m_strobe_low;
    logic [29:0] m_addr;
    logic        m_rw;
    logic [31:0] m_wd;
    logic [31:0] m_held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase      = 0;
        m_waited     = 0;
        m_req_low    = 1'b0;
        m_strobe_low = 1'b0;
        m_addr       = '0;
        m_rw         = READ;
        m_wd         = '0;
        m_held       = '0;
    endtask

    task automatic model_cycle();
        logic [31:0] e_rd;
        logic        e_busy, e_spm_strobe, e_err;
        logic        cpu_req, to_spm, ended, expired;
        e_rd         = '0;
        e_busy       = 1'b0;
        e_spm_strobe = 1'b0;
        e_err        = 1'b0;
        cpu_req      = !cpu_as_ && !flush;
        to_spm       = (int'(addr[29:27]) == SPM_I);
        ended        = 1'b0;
        expired      = 1'b0;

        if (m_phase == 0) begin
            if (cpu_req && to_spm && !stall) begin
                e_spm_strobe = 1'b1;
                if (rw == READ) e_rd = spm_rd_data;
            end
            if (cpu_req && !to_spm) e_busy = 1'b1;
        end else if (m_phase == 1) begin
            e_busy = 1'b1;
        end else if (m_phase == 2) begin
            ended   = !bus_rdy_;
            expired = !ended && (m_waited + 1 == TO_CYC);
            if (ended) begin
                if (m_rw == READ) e_rd = bus_rd_data;
            end else if (expired) begin
                e_err = 1'b1;
            end else begin
                e_busy = 1'b1;
            end
        end else begin
            if (m_rw == READ) e_rd = m_held;
        end

        chk("rd_data", rd_data, e_rd);
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("bus_err", {31'b0, bus_err}, {31'b0, e_err});
        chk("spm_as_", {31'b0, spm_as_}, {31'b0, !e_spm_strobe});
        chk("spm_addr", {2'b0, spm_addr}, {2'b0, addr});
        chk("spm_rw", {31'b0, spm_rw}, {31'b0, rw});
        chk("spm_wr_data", spm_wr_data, wr_data);
        chk("bus_req_", {31'b0, bus_req_}, {31'b0, !m_req_low});
        chk("bus_as_", {31'b0, bus_as_}, {31'b0, !m_strobe_low});
        chk("bus_addr", {2'b0, bus_addr}, {2'b0, m_addr});
        chk("bus_rw", {31'b0, bus_rw}, {31'b0, m_rw});
        chk("bus_wr_data", bus_wr_data, m_wd);

        if (reset) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (cpu_req && !to_spm) begin
                m_phase   = 1;
                m_req_low = 1'b1;
                m_addr    = addr;
                m_rw      = rw;
                m_wd      = wr_data;
            end
        end else if (m_phase == 1) begin
            if (flush) begin
                m_phase   = 0;
                m_req_low = 1'b0;
            end else if (!bus_grnt_) begin
                m_phase      = 2;
                m_waited     = 0;
                m_strobe_low = 1'b1;
            end
        end else if (m_phase == 2) begin
            m_strobe_low = 1'b0;
            if (ended || expired) begin
                m_req_low = 1'b0;
                if (ended && m_rw == READ) m_held = bus_rd_data;
                if (expired) m_held = '0;
                m_phase  = stall ? 3 : 0;
                m_waited = 0;
            end else begin
                m_waited++;
            end
        end else begin
            if (!stall) m_phase = 0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    function automatic logic [29:0] mk_addr(input logic [2:0] idx, input logic [26:0] low);
        return {idx, low};
    endfunction

    // Issue a bus request and have it granted immediately; returns at the first ACCESS cycle
    task automatic start_bus(input logic [2:0] idx, input logic dir, input logic [31:0] wd);
        addr      = mk_addr(idx, 27'h0123456);
        rw        = dir;
        wr_data   = wd;
        cpu_as_   = 1'b0;
        bus_grnt_ = 1'b1;
        tick();
        bus_grnt_ = 1'b0;
        tick();
        bus_grnt_ = 1'b1;
    endtask

    task automatic idle_inputs();
        cpu_as_   = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        bus_grnt_ = 1'b1;
        bus_rdy_  = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        reset       = 1'b1;
        idle_inputs();
        addr        = '0;
        rw          = READ;
        wr_data     = '0;
        spm_rd_data = '0;
        bus_rd_data = '0;
        adv();
        tick();
        reset = 1'b0;

        // Reset state
        sample();
        chk("rst_bus_req_", {31'b0, bus_req_}, 32'd1);
        chk("rst_bus_as_", {31'b0, bus_as_}, 32'd1);
        chk("rst_bus_addr", {2'b0, bus_addr}, 32'd0);
        chk("rst_bus_rw", {31'b0, bus_rw}, 32'd1);
        chk("rst_bus_wr_data", bus_wr_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        adv();

        // SPM read, zero wait
        addr        = mk_addr(3'd1, 27'h0000040);
        rw          = READ;
        cpu_as_     = 1'b0;
        spm_rd_data = 32'hCAFEF00D;
        sample();
        chk("spm_rd", rd_data, 32'hCAFEF00D);
        chk("spm_strobe", {31'b0, spm_as_}, 32'd0);
        chk("spm_busy", {31'b0, busy}, 32'd0);
        adv();

        // Bus write: grant after 2 REQ cycles, ready on the 3rd ACCESS cycle
        addr    = mk_addr(3'd3, 27'h0000055);
        rw      = WRITE;
        wr_data = 32'hA5A50F0F;
        sample();
        chk("bw_busy0", {31'b0, busy}, 32'd1);
        chk("bw_req0", {31'b0, bus_req_}, 32'd1);
        adv();
        wr_data = 32'h0;
        sample();
        chk("bw_req1", {31'b0, bus_req_}, 32'd0);
        chk("bw_wdata", bus_wr_data, 32'hA5A50F0F);
        adv();
        tick();
        bus_grnt_ = 1'b0;
        tick();
        bus_grnt_ = 1'b1;
        sample();
        chk("bw_as_first", {31'b0, bus_as_}, 32'd0);
        chk("bw_busy_acc", {31'b0, busy}, 32'd1);
        adv();
        sample();
        chk("bw_as_second", {31'b0, bus_as_}, 32'd1);
        adv();
        bus_rdy_ = 1'b0;
        sample();
        chk("bw_busy_rdy", {31'b0, busy}, 32'd0);
        adv();
        idle_inputs();
        sample();
        chk("bw_req_done", {31'b0, bus_req_}, 32'd1);
        adv();

        // Bus read finishing under stall, result replayed until stall drops
        start_bus(3'd5, READ, 32'h0);
        bus_rdy_    = 1'b0;
        bus_rd_data = 32'h12345678;
        stall       = 1'b1;
        sample();
        chk("br_rd", rd_data, 32'h12345678);
        chk("br_busy", {31'b0, busy}, 32'd0);
        adv();
        bus_rdy_    = 1'b1;
        bus_rd_data = 32'h0;
        cpu_as_     = 1'b1;
        tick();
        sample();
        chk("br_hold", rd_data, 32'h12345678);
        adv();
        stall = 1'b0;
        sample();
        chk("br_hold_last", rd_data, 32'h12345678);
        adv();
        sample();
        chk("br_idle", rd_data, 32'h0);
        adv();

        // Timeout on the 4th ACCESS cycle
        start_bus(3'd2, READ, 32'h0);
        bus_rd_data = 32'hFFFF0000;
        for (int k = 0; k < TO_CYC - 1; k++) begin
            sample();
            chk("to_busy_wait", {31'b0, busy}, 32'd1);
            adv();
        end
        sample();
        chk("to_err", {31'b0, bus_err}, 32'd1);
        chk("to_rd", rd_data, 32'h0);
        chk("to_busy", {31'b0, busy}, 32'd0);
        adv();
        idle_inputs();
        sample();
        chk("to_req", {31'b0, bus_req_}, 32'd1);
        chk("to_err_gone", {31'b0, bus_err}, 32'd0);
        adv();

        // Flush while waiting for grant
        addr    = mk_addr(3'd4, 27'h0000001);
        cpu_as_ = 1'b0;
        tick();
        flush = 1'b1;
        sample();
        chk("fl_busy_req", {31'b0, busy}, 32'd1);
        adv();
        idle_inputs();
        sample();
        chk("fl_req", {31'b0, bus_req_}, 32'd1);
        chk("fl_as", {31'b0, bus_as_}, 32'd1);
        chk("fl_busy", {31'b0, busy}, 32'd0);
        adv();

        // Reset in the middle of ACCESS
        start_bus(3'd6, WRITE, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        sample();
        chk("ra_req", {31'b0, bus_req_}, 32'd1);
        chk("ra_as", {31'b0, bus_as_}, 32'd1);
        chk("ra_addr", {2'b0, bus_addr}, 32'd0);
        chk("ra_rw", {31'b0, bus_rw}, 32'd1);
        chk("ra_wdata", bus_wr_data, 32'd0);
        chk("ra_busy", {31'b0, busy}, 32'd0);
        adv();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            cpu_as_     = ($urandom_range(0, 9) < 3);
            rw          = 1'($urandom_range(0, 1));
            addr        = mk_addr(($urandom_range(0, 1) == 1) ? 3'(SPM_I) : 3'($urandom_range(0, 7)),
                                  27'($urandom));
            wr_data     = $urandom;
            spm_rd_data = $urandom;
            bus_rd_data = $urandom;
            bus_grnt_   = ($urandom_range(0, 9) < 6);
            bus_rdy_    = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
